prim_ram_2p_fill_check: RTL

//  Initiator for one port of the dual-port RAM: walks every address, writes a seeded pattern
//  (fill), then reads it back and compares (check). Sits next to the RAM on the port left

---
 rtl/prim_ram_2p_fill_check.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/prim_ram_2p_fill_check.sv
// prim_ram_2p_fill_check: RAM fill and read-back checker.
// Drives one RAM port, writes seed^addr, then verifies it.
module prim_ram_2p_fill_check #(
  parameter  int Width = 32,
  parameter  int Depth = 128,
  localparam int Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [Width-1:0] seed_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [Aw:0]      err_cnt_o,
  output logic [Aw-1:0]    first_err_addr_o,
  output logic             req_o,
  output logic             write_o,
  output logic [Aw-1:0]    addr_o,
  output logic [Width-1:0] wdata_o,
  output logic [Width-1:0] wmask_o,
  input  logic [Width-1:0] rdata_i
);

  localparam logic [Aw-1:0] LAST = Aw'(Depth - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CHECK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [Aw-1:0]    r_cnt;
  logic [Aw-1:0]    w_cnt_nxt;
  logic             w_start;
  logic             r_do_chk;
  logic [Width-1:0] r_seed;
  logic             r_rd_pend;
  logic [Aw-1:0]    r_exp_addr;
  logic             r_err;
  logic [Aw:0]      r_err_cnt;
  logic [Aw-1:0]    r_first;
  logic             w_miss;

  function automatic logic [Width-1:0] f_pat(
    input logic [Width-1:0] s,
    input logic [Aw-1:0]    a
  );
    return s ^ Width'(a);
  endfunction

  // Next state and address counter; abort wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          w_start   = 1'b1;
          w_cnt_nxt = '0;
          if (mode_i[0])      w_state_nxt = S_FILL;
          else if (mode_i[1]) w_state_nxt = S_CHECK;
          else                w_state_nxt = S_DONE;
        end
      end
      S_FILL: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_do_chk ? S_CHECK : S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_CHECK: begin
        if (abort_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DRAIN: w_state_nxt = abort_i ? S_IDLE : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and run configuration registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_do_chk <= 1'b0;
      r_seed   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_start) begin
        r_do_chk <= mode_i[1];
        r_seed   <= seed_i;
      end
    end
  end

  // Read pipeline: remember which address the returning data belongs to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_pend  <= 1'b0;
      r_exp_addr <= '0;
    end else begin
      r_rd_pend  <= (r_state == S_CHECK) && !abort_i;
      r_exp_addr <= r_cnt;
    end
  end

  assign w_miss = r_rd_pend && (rdata_i != f_pat(r_seed, r_exp_addr));

  // Error tracking; cleared only by an accepted start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_first   <= '0;
    end else if (w_start) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_first   <= '0;
    end else if (w_miss) begin
      r_err     <= 1'b1;
      r_err_cnt <= r_err_cnt + 1'b1;
      if (!r_err) r_first <= r_exp_addr;
    end
  end

  // RAM port and status decode from registered state only.
  always_comb begin
    req_o   = 1'b0;
    write_o = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    unique case (1'b1)
      r_state == S_FILL: begin
        req_o   = 1'b1;
        write_o = 1'b1;
        addr_o  = r_cnt;
        wdata_o = f_pat(r_seed, r_cnt);
      end
      r_state == S_CHECK: begin
        req_o  = 1'b1;
        addr_o = r_cnt;
      end
      default: ;
    endcase
  end

  assign wmask_o          = '1;
  assign busy_o           = (r_state != S_IDLE);
  assign done_o           = (r_state == S_DONE);
  assign err_o            = r_err;
  assign err_cnt_o        = r_err_cnt;
  assign first_err_addr_o = r_first;

endmodule
